// File: rtl/regfile_save_restore_pkg.sv
// regfile_save_restore_pkg: shared state encoding and mode constants
package regfile_save_restore_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2,
        DONE    = 2'd3
    } state_t;
    localparam logic MODE_SAVE    = 1'b0;
    localparam logic MODE_RESTORE = 1'b1;
    function automatic state_t start_state(input logic mode);
        return (mode == MODE_SAVE) ? SAVE : (mode == MODE_RESTORE) ? RESTORE : IDLE;
    endfunction
endpackage

// File: rtl/regfile_ptr_counter.sv
// regfile_ptr_counter: register address pointer that loads FIRSTREG and stops at LASTREG
module regfile_ptr_counter #(
    parameter int ADDRBITS = 5,
    parameter int FIRSTREG = 1,
    parameter int LASTREG  = 31
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                i_load,
    input  logic                i_inc,
    output logic [ADDRBITS-1:0] o_ptr,
    output logic                o_last
);
    localparam logic [ADDRBITS-1:0] FIRST = ADDRBITS'(FIRSTREG);
    localparam logic [ADDRBITS-1:0] LAST  = ADDRBITS'(LASTREG);
    logic [ADDRBITS-1:0] r_ptr;
    // pointer reloads at transfer start and advances once per accepted word, never past LAST
    always_ff @(posedge Clk) begin
        if (Reset || i_load) r_ptr <= FIRST;
        else if (i_inc && !o_last) r_ptr <= r_ptr + 1'b1;
    end
    assign o_ptr  = r_ptr;
    assign o_last = (r_ptr == LAST);
endmodule

// File: rtl/regfile_save_restore.sv
// regfile_save_restore: streams registers FIRSTREG..LASTREG out of or into the register file
module regfile_save_restore
    import regfile_save_restore_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDRBITS = 5,
    parameter int FIRSTREG = 1,
    parameter int LASTREG  = 31
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Mode,
    output logic                Busy,
    output logic                Done,
    output logic [ADDRBITS-1:0] ReadRegister,
    input  logic [WIDTH-1:0]    ReadData,
    output logic [ADDRBITS-1:0] WriteRegister,
    output logic [WIDTH-1:0]    WriteData,
    output logic                RegWrite,
    output logic [WIDTH-1:0]    OutData,
    output logic                OutValid,
    input  logic                OutReady,
    input  logic [WIDTH-1:0]    InData,
    input  logic                InValid,
    output logic                InReady
);
    state_t              r_state, w_next;
    logic                w_load, w_hs, w_last;
    logic [ADDRBITS-1:0] w_ptr;

    regfile_ptr_counter #(
        .ADDRBITS(ADDRBITS),
        .FIRSTREG(FIRSTREG),
        .LASTREG (LASTREG)
    ) u_ptr (
        .Clk   (Clk),
        .Reset (Reset),
        .i_load(w_load),
        .i_inc (w_hs),
        .o_ptr (w_ptr),
        .o_last(w_last)
    );

    // state register
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next state and port drive; valid/ready outputs depend only on state so no stream-to-stream comb path
    always_comb begin
        w_load        = (r_state == IDLE) && Start;
        w_hs          = ((r_state == SAVE) && OutReady) || ((r_state == RESTORE) && InValid);
        w_next        = w_load ? start_state(Mode) :
                        (w_hs && w_last) ? DONE :
                        (r_state == DONE) ? IDLE : r_state;
        Busy          = (r_state == SAVE) || (r_state == RESTORE);
        Done          = (r_state == DONE);
        OutValid      = (r_state == SAVE);
        InReady       = (r_state == RESTORE);
        RegWrite      = (r_state == RESTORE) && InValid;
        ReadRegister  = w_ptr;
        WriteRegister = w_ptr;
        OutData       = ReadData;
        WriteData     = InData;
    end
endmodule

// File: tb/tb_regfile_save_restore.sv
// tb_regfile_save_restore: vector table plus scoreboarded save/restore runs against a behavioural regfile
module tb_regfile_save_restore;
    logic        Clk = 0, Reset = 1, Start = 0, Mode = 0;
    logic        Busy, Done, RegWrite, OutValid, OutReady = 0, InValid = 0, InReady;
    logic [4:0]  ReadRegister, WriteRegister;
    logic [31:0] ReadData, WriteData, OutData, InData = 0;

    typedef struct packed {logic [4:0] addr; logic [31:0] data;} word_t;
    typedef struct packed {
        logic start, mode, in_valid, out_ready;
        logic [4:0] exp_flags;
        logic [4:0] exp_ptr;
    } vec_t;

    word_t       sq[$], rq[$];
    vec_t        vecs[7];
    logic [31:0] rf[32], exp_rf[32], nd[32];
    int          n_checks = 0, n_fail = 0, busy_cnt = 0, done_cnt = 0, words = 0;
    bit          sb_en = 0;

    regfile_save_restore dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Busy(Busy), .Done(Done),
        .ReadRegister(ReadRegister), .ReadData(ReadData), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .RegWrite(RegWrite), .OutData(OutData), .OutValid(OutValid),
        .OutReady(OutReady), .InData(InData), .InValid(InValid), .InReady(InReady)
    );

    always #5 Clk = ~Clk;

    initial for (int i = 0; i < 32; i++) begin rf[i] = 0; exp_rf[i] = 0; end
    always @(posedge Clk) if (RegWrite && WriteRegister != 0) rf[WriteRegister] <= WriteData;
    assign ReadData = (ReadRegister == 0) ? 32'd0 : rf[ReadRegister];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) if (sb_en) begin
        if (Busy) busy_cnt++;
        if (Done) done_cnt++;
        if (OutValid) begin
            if (sq.size() == 0) check("save_extra_word", 1, 0);
            else begin
                check("save_addr", ReadRegister, sq[0].addr);
                check("save_data", OutData, sq[0].data);
                if (OutReady) begin void'(sq.pop_front()); words++; end
            end
        end
        if (RegWrite) begin
            if (rq.size() == 0) check("restore_extra_write", 1, 0);
            else begin
                check("restore_addr", WriteRegister, rq[0].addr);
                check("restore_data", WriteData, rq[0].data);
                void'(rq.pop_front());
                words++;
            end
        end
    end

    task automatic do_reset();
        Reset = 1; Start = 0; InValid = 0; OutReady = 0;
        repeat (2) @(posedge Clk);
        #1 Reset = 0;
    endtask

    task automatic start_xfer(input logic m);
        busy_cnt = 0; done_cnt = 0; words = 0;
        Start = 1; Mode = m;
        @(posedge Clk); #1 Start = 0;
        check("busy_after_start", Busy, 1);
    endtask

    task automatic run_restore(input int n, input bit gap);
        start_xfer(1);
        for (int k = 1; k <= n; k++) begin
            if (gap && k > 1) begin InValid = 0; @(posedge Clk); #1; end
            InValid = 1; InData = nd[k];
            rq.push_back('{5'(k), nd[k]});
            exp_rf[k] = nd[k];
            @(posedge Clk); #1;
        end
        InValid = 0;
    endtask

    task automatic run_save(input bit bp, input bit poke);
        int i = 0;
        for (int k = 1; k <= 31; k++) sq.push_back('{5'(k), exp_rf[k]});
        start_xfer(0);
        while (sq.size() > 0 && i < 200) begin
            OutReady = bp ? (i % 4 == 0 || i % 4 == 3) : 1'b1;
            Start = poke && i == 5; Mode = 1;
            @(posedge Clk); #1 i++;
        end
        OutReady = 0; Start = 0;
        check("save_budget", i < 200, 1);
        if (poke) begin Start = 1; @(posedge Clk); #1 Start = 0; end
    endtask

    task automatic finish_xfer(input string name, input int exp_total);
        repeat (3) @(posedge Clk);
        #1;
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_cycles"}, busy_cnt + done_cnt, exp_total);
        check({name, "_words"}, words, 31);
        check({name, "_queues_empty"}, sq.size() + rq.size(), 0);
        check({name, "_idle_after"}, {Busy, Done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'd1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b00000, 5'd1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10010, 5'd1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b10011, 5'd1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b10011, 5'd2};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b10010, 5'd3};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10010, 5'd3};
        do_reset();
        for (int v = 0; v < 7; v++) begin
            Start = vecs[v].start; Mode = vecs[v].mode;
            InValid = vecs[v].in_valid; OutReady = vecs[v].out_ready;
            @(negedge Clk);
            check($sformatf("vec%0d_flags", v), {Busy, Done, OutValid, InReady, RegWrite}, vecs[v].exp_flags);
            check($sformatf("vec%0d_ptr", v), ReadRegister, vecs[v].exp_ptr);
            @(posedge Clk); #1;
        end
        do_reset();
        @(negedge Clk);
        check("reset_flags", {Busy, Done, OutValid, InReady, RegWrite}, 0);
        check("reset_ptr", ReadRegister, 1);
        @(posedge Clk); #1 sb_en = 1;

        for (int k = 0; k < 32; k++) nd[k] = 32'h1000_0000 + k;
        run_restore(31, 0);
        finish_xfer("restore_full", 32);
        run_save(0, 0);
        finish_xfer("save_full", 32);
        run_save(1, 0);
        finish_xfer("save_backpressure", 62);

        for (int k = 0; k < 32; k++) nd[k] = 32'h2000_0000 + k;
        run_restore(31, 1);
        finish_xfer("restore_gaps", 62);

        for (int k = 0; k < 32; k++) nd[k] = 32'h3000_0000 + k;
        run_restore(10, 0);
        Reset = 1;
        @(posedge Clk); #1 Reset = 0;
        @(negedge Clk);
        check("midreset_flags", {Busy, Done, OutValid, InReady, RegWrite}, 0);
        check("midreset_ptr", ReadRegister, 1);
        check("midreset_writes", rq.size(), 0);
        @(posedge Clk); #1;
        run_save(0, 0);
        finish_xfer("save_after_midreset", 32);

        for (int k = 0; k < 32; k++) nd[k] = k[0] ? 32'hFFFF_FFFF : 32'h0;
        run_restore(31, 0);
        finish_xfer("restore_alt", 32);
        run_save(0, 1);
        finish_xfer("save_alt_poked", 32);
        check("reg0_untouched", rf[0], 0);

        sb_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
